toggle_monitor: RTL

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

---
 rtl/toggle_mon_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/toggle_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/toggle_mon_pkg.sv
// Shared definitions for the toggle monitor: FSM state encoding and
// default parameter values.
package toggle_mon_pkg;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned TIMEOUT_DEF     = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        STUCK  = 2'd3
    } state_t;

    // Edges are only counted once the monitor has left IDLE.
    function automatic logic state_counts(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the asynchronous q_in, keeps a one-cycle delayed copy and
// emits a registered pulse on every rising or falling edge.
module sync_edge_det
    import toggle_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic q_in,
    output logic edge_det_c,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   q_s;
    logic                   q_d;

    assign q_s        = sync[SYNC_STAGES-1];
    assign edge_det_c = q_s ^ q_d;

    // Reset clears the whole pipeline so no pre-reset sample can produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            q_d        <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], q_in};
            q_d        <= q_s;
            edge_pulse <= edge_det_c;
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// Counts edges of an asynchronous toggle-element output and flags the input
// as stuck when no edge is seen for TIMEOUT cycles while active.
module toggle_monitor
    import toggle_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             q_in,
    input  logic             clr,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             edge_pulse,
    output logic             cnt_sat,
    output logic             stuck,
    output logic [1:0]       state
);

    localparam int unsigned      TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_n;
    logic [TO_W-1:0]  to_q;
    logic [TO_W-1:0]  to_n;
    logic [CNT_W-1:0] cnt_n;
    logic             sat_n;
    logic             stuck_n;
    logic             edge_det_c;
    logic             count_c;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .edge_det_c (edge_det_c),
        .edge_pulse (edge_pulse)
    );

    // State, timeout and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            to_q       <= '0;
            toggle_cnt <= '0;
            cnt_sat    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state_q    <= state_n;
            to_q       <= to_n;
            toggle_cnt <= cnt_n;
            cnt_sat    <= sat_n;
            stuck      <= stuck_n;
        end
    end

    // Next-state and timeout logic; en=0 forces IDLE from anywhere.
    always_comb begin
        state_n = state_q;
        to_n    = to_q;
        if (!en) begin
            state_n = IDLE;
            to_n    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = ARMED;
                    to_n    = '0;
                end
                ARMED: begin
                    to_n = '0;
                    if (edge_det_c) begin
                        state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (edge_det_c) begin
                        to_n = '0;
                    end else if (to_q == TO_LAST) begin
                        state_n = STUCK;
                        to_n    = '0;
                    end else begin
                        to_n = to_q + TO_W'(1);
                    end
                end
                STUCK: begin
                    to_n = '0;
                    if (edge_det_c) begin
                        state_n = ACTIVE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    to_n    = '0;
                end
            endcase
        end
        stuck_n = (state_n == STUCK);
    end

    // Saturating edge counter; clr overrides a coincident counted edge.
    always_comb begin
        count_c = en && edge_det_c && state_counts(state_q);
        cnt_n   = toggle_cnt;
        sat_n   = cnt_sat;
        if (clr) begin
            cnt_n = '0;
            sat_n = 1'b0;
        end else if (count_c) begin
            if (toggle_cnt == CNT_MAX) begin
                sat_n = 1'b1;
            end else begin
                cnt_n = toggle_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule
